// File: rtl/cla_pkg.sv
// cla_pkg: shared slice width, slice count and scheduler state encoding.
package cla_pkg;
    localparam int SLICE_W = 4;
    localparam int DATA_W_DEF = 16;
    localparam int SLICE_N = DATA_W_DEF / SLICE_W;
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
endpackage

// File: rtl/carry_look_ahead.sv
// carry_look_ahead: 4-bit adder with fully expanded look-ahead carries.
module carry_look_ahead (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s = p ^ c[3:0];
    assign cout = c[4];
endmodule

// File: rtl/cla_add_scheduler.sv
// cla_add_scheduler: two-requester round-robin front end sharing one 4-bit
// look-ahead slice to build a DATA_W add serially, LSB slice first.
module cla_add_scheduler #(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = cla_pkg::SLICE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_cin,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_cin,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_sum,
    output logic              resp_cout
);
    localparam int N  = DATA_W / SLICE_W;
    localparam int IW = N > 1 ? $clog2(N) : 1;

    cla_pkg::state_t   state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              carry_q, carry_d, last_q, last_d, id_q, id_d, cout_q, cout_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [SLICE_W-1:0] s_a, s_b, s_s;
    logic              s_co, idle;

    // last_q=1 means req1 was granted last, so req0 wins the next tie.
    assign idle       = (state_q == cla_pkg::IDLE) && !rst;
    assign req0_ready = idle && req0_valid && (!req1_valid || last_q);
    assign req1_ready = idle && req1_valid && (!req0_valid || !last_q);
    assign s_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign s_b = b_q[idx_q*SLICE_W +: SLICE_W];

    carry_look_ahead u_cla (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry_q),
        .s    (s_s),
        .cout (s_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        last_d  = last_q;
        id_d    = id_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        if (req0_ready || req1_ready) begin
            id_d    = req1_ready;
            last_d  = req1_ready;
            a_d     = req1_ready ? req1_a : req0_a;
            b_d     = req1_ready ? req1_b : req0_b;
            carry_d = req1_ready ? req1_cin : req0_cin;
            idx_d   = '0;
            state_d = cla_pkg::CALC;
        end
        if (state_q == cla_pkg::CALC) begin
            sum_d[idx_q*SLICE_W +: SLICE_W] = s_s;
            carry_d = s_co;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(N - 1)) begin
                cout_d  = s_co;
                state_d = cla_pkg::RESP;
            end
        end
        if (state_q == cla_pkg::RESP && resp_ready)
            state_d = cla_pkg::IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= cla_pkg::IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            last_q  <= last_d;
            id_q    <= id_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign resp_valid = (state_q == cla_pkg::RESP);
    assign resp_id    = id_q;
    assign resp_sum   = sum_q;
    assign resp_cout  = cout_q;
endmodule

// File: tb/tb_cla_add_scheduler.sv
// tb_cla_add_scheduler: table vectors, tie/stall/reset sequences and random
// traffic checked against plain a+b+cin arithmetic and a round-robin model.
module tb_cla_add_scheduler;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        req0_cin = 0, req1_cin = 0;
    logic        resp_valid, resp_ready = 0, resp_id, resp_cout;
    logic [15:0] resp_sum;
    int          n_run = 0, n_fail = 0;
    bit          tb_last = 1'b1;

    cla_add_scheduler #(.DATA_W(16), .SLICE_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_cout(resp_cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          id;
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_run++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Presents an operation, predicts the winner, checks latency/result/hold and completes the handshake.
    task automatic do_op(input string nm, input bit v0, input bit v1,
                         input logic [15:0] a0, input logic [15:0] b0, input logic c0,
                         input logic [15:0] a1, input logic [15:0] b1, input logic c1,
                         input int stall, output logic [15:0] got_sum, output logic got_cout);
        bit          w;
        logic [16:0] want;
        int          lat;
        w    = (v0 && v1) ? !tb_last : v1;
        want = w ? 17'(a1) + 17'(b1) + 17'(c1) : 17'(a0) + 17'(b0) + 17'(c0);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
        #1;
        chk({nm, " ready0"}, req0_ready, !w);
        chk({nm, " ready1"}, req1_ready, w);
        @(posedge clk);
        tb_last = w;
        #1;
        if (w) req1_valid = 0; else req0_valid = 0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            chk({nm, " busy ready"}, {req0_ready, req1_ready}, 0);
            @(posedge clk); #1; lat++;
        end
        chk({nm, " latency"}, lat, 4);
        chk({nm, " sum"}, resp_sum, want[15:0]);
        chk({nm, " cout"}, resp_cout, want[16]);
        chk({nm, " id"}, resp_id, w);
        got_sum = resp_sum; got_cout = resp_cout;
        repeat (stall) begin
            @(posedge clk); #1;
            chk({nm, " hold valid"}, resp_valid, 1);
            chk({nm, " hold sum"}, resp_sum, want[15:0]);
            chk({nm, " hold cout"}, resp_cout, want[16]);
            chk({nm, " hold id"}, resp_id, w);
            chk({nm, " hold ready"}, {req0_ready, req1_ready}, 0);
        end
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        chk({nm, " valid after hs"}, resp_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        logic [15:0] s;
        logic        co;
        bit          seen;
        tbl[0] = '{0, 16'h0002, 16'h0008, 1'b0, 16'h000A, 1'b0};
        tbl[1] = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        tbl[3] = '{1, 16'h0005, 16'h0006, 1'b1, 16'h000C, 1'b0};
        tbl[4] = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[5] = '{1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("reset ready", {req0_ready, req1_ready}, 0);
        chk("reset valid", resp_valid, 0);
        chk("reset sum", resp_sum, 0);
        chk("reset cout", resp_cout, 0);
        chk("reset id", resp_id, 0);
        req0_valid = 0; req1_valid = 0;
        rst = 0;

        do_op("tie0", 1, 1, 16'h0F0F, 16'h0101, 0, 16'h8000, 16'h8000, 0, 0, s, co);
        chk("tie0 const", {co, s}, 17'h01010);
        chk("tie1 held ready", req1_ready, 1);
        do_op("tie1", 0, 1, 16'h0F0F, 16'h0101, 0, 16'h8000, 16'h8000, 0, 0, s, co);
        chk("tie1 const", {co, s}, 17'h10000);
        do_op("tie2", 1, 1, 16'h0001, 16'h0002, 0, 16'h0003, 16'h0004, 0, 0, s, co);
        chk("tie2 id", tb_last, 0);

        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("tbl%0d", i), !tbl[i].id, tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin,
                  tbl[i].a, tbl[i].b, tbl[i].cin, 0, s, co);
            chk($sformatf("tbl%0d result", i), {co, s}, {tbl[i].cout, tbl[i].sum});
        end

        do_op("stall", 1, 1, 16'h00FF, 16'h0F01, 0, 16'h7FFF, 16'h0001, 1, 3, s, co);
        chk("stall release ready", {req0_ready, req1_ready}, tb_last ? 2'b10 : 2'b01);
        req0_valid = 0; req1_valid = 0;

        req0_valid = 1; req0_a = 16'h00AA; req0_b = 16'h0055; req0_cin = 0;
        #1;
        chk("abort accept ready", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        @(posedge clk); #1;
        rst = 1; req0_valid = 1;
        #1;
        chk("abort rst ready", req0_ready, 0);
        @(posedge clk); #1;
        rst = 0; req0_valid = 0; tb_last = 1;
        chk("abort valid", resp_valid, 0);
        chk("abort sum", resp_sum, 0);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1;
        end
        chk("abort no resp", seen, 0);
        do_op("after abort", 1, 0, 16'h0005, 16'h0006, 1, 16'h0000, 16'h0000, 0, 0, s, co);
        chk("after abort const", {co, s}, 17'h0000C);

        for (int i = 0; i < 30; i++) begin
            int unsigned pat;
            pat = $urandom_range(1, 3);
            do_op($sformatf("rnd%0d", i), pat[0], pat[1],
                  16'($urandom), 16'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 1'($urandom),
                  $urandom_range(0, 3), s, co);
        end
        req0_valid = 0; req1_valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
